// File: rtl/v60_prefetch_queue_if.sv
// Fetch-bus and decoder-side signals of the v60 instruction prefetch queue.
// master: the queue itself; slave: the bus/decoder environment around it.
interface v60_prefetch_queue_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_data;
  logic [47:0] inst;
  logic        inst_valid;
  logic [2:0]  inst_avail;
  logic [31:0] inst_pc;
  logic        consume;
  logic [2:0]  consume_len;
  logic        flush;
  logic [31:0] flush_addr;
  logic [4:0]  byte_count;

  modport master (
    output fetch_req, fetch_addr, inst, inst_valid, inst_avail, inst_pc, byte_count,
    input  fetch_ack, fetch_data, consume, consume_len, flush, flush_addr
  );

  modport slave (
    input  fetch_req, fetch_addr, inst, inst_valid, inst_avail, inst_pc, byte_count,
    output fetch_ack, fetch_data, consume, consume_len, flush, flush_addr
  );
endinterface

// File: rtl/v60_prefetch_queue.sv
// Instruction prefetch queue: fetches aligned words, buffers bytes, presents a 6-byte decode window.
// Define V60_PREFETCH_PARTIAL_EN to expose the window as soon as one byte is held.
module v60_prefetch_queue #(
  parameter int          QUEUE_BYTES  = 16,
  parameter logic [31:0] RESET_VECTOR = 32'hFFFF_FFF0
) (
  input logic                  clk,
  input logic                  rst,
  v60_prefetch_queue_if.master bus
);

  // state | meaning
  // IDLE  | no request outstanding; waits for 4 free bytes
  // FETCH | request at fetch_addr outstanding; returned bytes are queued
  // DRAIN | request issued before a flush still outstanding; its data is dropped
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_t;

  localparam int         QW  = 8 * QUEUE_BYTES;
  localparam logic [5:0] QB6 = 6'(QUEUE_BYTES);

  state_t        state_q, state_d;
  logic          fetch_req_q, fetch_req_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   fetch_ptr_q, fetch_ptr_d;
  logic [1:0]    skip_q, skip_d;
  logic [31:0]   inst_pc_q, inst_pc_d;
  logic [4:0]    count_q, count_d;
  logic [QW-1:0] bytes_q, bytes_d;

  logic          win_valid;
  logic [2:0]    win_avail;
  logic [47:0]   win;
  logic          ack;
  logic          consume_ok;
  logic [2:0]    push_n;
  logic [2:0]    pop_n;
  logic [5:0]    free_now;
  logic [5:0]    free_after;
  logic [4:0]    wr_pos;
  logic [31:0]   push_word;
  logic [QW-1:0] shifted;
  logic [QW-1:0] inserted;

  // Byte 0 of bytes_q (bits 7:0) is the head; bytes above count_q are kept zero.
  always_comb begin
`ifdef V60_PREFETCH_PARTIAL_EN
    win_valid = (count_q != 5'd0);
    win_avail = (count_q >= 5'd6) ? 3'd6 : count_q[2:0];
`else
    win_valid = (count_q >= 5'd6);
    win_avail = win_valid ? 3'd6 : 3'd0;
`endif
    win = '0;
    for (int i = 0; i < 6; i++) begin
      if (i < int'(win_avail)) win[47-8*i -: 8] = bytes_q[8*i +: 8];
    end
  end

  always_comb begin
    ack        = fetch_req_q & bus.fetch_ack;
    consume_ok = bus.consume && win_valid && (bus.consume_len != 3'd0) &&
                 (bus.consume_len <= win_avail);
    pop_n      = consume_ok ? bus.consume_len : 3'd0;
    push_n     = (state_q == ST_FETCH && ack) ? (3'd4 - {1'b0, skip_q}) : 3'd0;
    wr_pos     = count_q - {2'b00, pop_n};
    free_now   = QB6 - {1'b0, count_q};
    // Space released by a same-cycle pop is deliberately not counted here.
    free_after = QB6 - ({1'b0, count_q} + {3'b000, push_n});
    push_word  = bus.fetch_data >> {skip_q, 3'b000};
    shifted    = bytes_q >> {pop_n, 3'b000};
    inserted   = QW'(push_word) << {wr_pos, 3'b000};

    if (bus.flush) begin
      bytes_d = '0;
      count_d = '0;
    end else begin
      bytes_d = (push_n != 3'd0) ? (shifted | inserted) : shifted;
      count_d = count_q + {2'b00, push_n} - {2'b00, pop_n};
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_req_d  = fetch_req_q;
    fetch_addr_d = fetch_addr_q;
    fetch_ptr_d  = fetch_ptr_q;
    skip_d       = skip_q;
    inst_pc_d    = consume_ok ? (inst_pc_q + 32'(pop_n)) : inst_pc_q;

    case (state_q)
      ST_IDLE: begin
        if (!bus.flush && free_now >= 6'd4) begin
          state_d      = ST_FETCH;
          fetch_req_d  = 1'b1;
          fetch_addr_d = fetch_ptr_q;
        end
      end
      ST_FETCH: begin
        if (ack) begin
          fetch_ptr_d = fetch_ptr_q + 32'd4;
          skip_d      = 2'b00;
          if (!bus.flush && free_after >= 6'd4) begin
            fetch_addr_d = fetch_ptr_q + 32'd4;
          end else begin
            state_d     = ST_IDLE;
            fetch_req_d = 1'b0;
          end
        end else if (bus.flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ack) begin
          if (bus.flush) begin
            state_d     = ST_IDLE;
            fetch_req_d = 1'b0;
          end else begin
            state_d      = ST_FETCH;
            fetch_addr_d = fetch_ptr_q;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        fetch_req_d = 1'b0;
      end
    endcase

    if (bus.flush) begin
      inst_pc_d   = bus.flush_addr;
      fetch_ptr_d = {bus.flush_addr[31:2], 2'b00};
      skip_d      = bus.flush_addr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= {RESET_VECTOR[31:2], 2'b00};
      fetch_ptr_q  <= {RESET_VECTOR[31:2], 2'b00};
      skip_q       <= RESET_VECTOR[1:0];
      inst_pc_q    <= RESET_VECTOR;
      count_q      <= '0;
      bytes_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_req_q  <= fetch_req_d;
      fetch_addr_q <= fetch_addr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      skip_q       <= skip_d;
      inst_pc_q    <= inst_pc_d;
      count_q      <= count_d;
      bytes_q      <= bytes_d;
    end
  end

  assign bus.fetch_req  = fetch_req_q;
  assign bus.fetch_addr = fetch_addr_q;
  assign bus.inst       = win;
  assign bus.inst_valid = win_valid;
  assign bus.inst_avail = win_avail;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.byte_count = count_q;

endmodule

// File: tb/tb_v60_prefetch_queue.sv
// Scoreboard bench for v60_prefetch_queue: directed stimulus queues expectations, a monitor compares.
module tb_v60_prefetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  v60_prefetch_queue_if bus();

  v60_prefetch_queue #(.QUEUE_BYTES(16), .RESET_VECTOR(32'hFFFF_FFF0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // head: the oldest held bytes left-justified (oldest in 47:40), zero beyond the held count.
  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [4:0]  cnt;
    logic [47:0] head;
    int          req;
    logic [31:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          checks = 0;
  int          failures = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic void win_rule(input logic [4:0] cnt, input logic [47:0] head,
                                   output logic v, output logic [2:0] a, output logic [47:0] w);
`ifdef V60_PREFETCH_PARTIAL_EN
    v = (cnt != 0);
    a = (cnt >= 6) ? 3'd6 : cnt[2:0];
`else
    v = (cnt >= 6);
    a = v ? 3'd6 : 3'd0;
`endif
    w = '0;
    for (int i = 0; i < 6; i++)
      if (i < int'(a)) w[47-8*i -: 8] = head[47-8*i -: 8];
  endfunction

  initial begin : monitor
    exp_t        e;
    logic        v;
    logic [2:0]  a;
    logic [47:0] w;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      if (bus.fetch_req === 1'b1 && bus.fetch_ack === 1'b1) begin
        if (addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got ack at addr %0h want none", bus.fetch_addr);
        end else begin
          ea = addr_q.pop_front();
          chk("fetch_addr_at_ack", 64'(bus.fetch_addr), 64'(ea));
        end
      end
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        win_rule(e.cnt, e.head, v, a, w);
        chk({e.name, ".inst_pc"},    64'(bus.inst_pc),    64'(e.pc));
        chk({e.name, ".byte_count"}, 64'(bus.byte_count), 64'(e.cnt));
        chk({e.name, ".inst_valid"}, 64'(bus.inst_valid), 64'(v));
        chk({e.name, ".inst_avail"}, 64'(bus.inst_avail), 64'(a));
        chk({e.name, ".inst"},       64'(bus.inst),       64'(w));
        if (e.req >= 0) chk({e.name, ".fetch_req"}, 64'(bus.fetch_req), 64'(e.req));
        if (e.req == 1) chk({e.name, ".fetch_addr"}, 64'(bus.fetch_addr), 64'(e.addr));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string name, input logic [31:0] pc, input logic [4:0] cnt,
                           input logic [47:0] head, input int req, input logic [31:0] addr);
    exp_t e;
    e.name = name; e.pc = pc; e.cnt = cnt; e.head = head; e.req = req; e.addr = addr;
    exp_q.push_back(e);
    tick(1);
  endtask

  task automatic ack_word(input logic [31:0] ea, input logic [31:0] d);
    int n = 0;
    while (bus.fetch_req !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    if (bus.fetch_req !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL req_timeout: got fetch_req=0 want request at %0h", ea);
    end else begin
      addr_q.push_back(ea);
      bus.fetch_ack  = 1'b1;
      bus.fetch_data = d;
      tick(1);
      bus.fetch_ack  = 1'b0;
      bus.fetch_data = '0;
    end
  endtask

  task automatic do_consume(input logic [2:0] len);
    bus.consume     = 1'b1;
    bus.consume_len = len;
    tick(1);
    bus.consume     = 1'b0;
    bus.consume_len = '0;
  endtask

  task automatic do_flush(input logic [31:0] fa);
    bus.flush      = 1'b1;
    bus.flush_addr = fa;
    tick(1);
    bus.flush      = 1'b0;
  endtask

  task automatic do_flush_ack(input logic [31:0] fa, input logic [31:0] ea, input logic [31:0] d);
    addr_q.push_back(ea);
    bus.flush      = 1'b1;
    bus.flush_addr = fa;
    bus.fetch_ack  = 1'b1;
    bus.fetch_data = d;
    tick(1);
    bus.flush      = 1'b0;
    bus.fetch_ack  = 1'b0;
    bus.fetch_data = '0;
  endtask

  initial begin : stimulus
    bus.fetch_ack   = 1'b0;
    bus.fetch_data  = '0;
    bus.consume     = 1'b0;
    bus.consume_len = '0;
    bus.flush       = 1'b0;
    bus.flush_addr  = '0;
    tick(2);
    // expect_st returns one edge later, so reset stays asserted through its check
    expect_st("reset", 32'hFFFF_FFF0, 5'd0, 48'h0, 0, 32'h0);
    rst = 1'b0;

    ack_word(32'hFFFF_FFF0, 32'h4433_2211);
    ack_word(32'hFFFF_FFF4, 32'h8877_6655);
    expect_st("two_words", 32'hFFFF_FFF0, 5'd8, 48'h1122_3344_5566, 1, 32'hFFFF_FFF8);

    do_consume(3'd5);
    expect_st("consume5", 32'hFFFF_FFF5, 5'd3, 48'h6677_8800_0000, 1, 32'hFFFF_FFF8);
    do_consume(3'd4);
    expect_st("consume_over_avail", 32'hFFFF_FFF5, 5'd3, 48'h6677_8800_0000, 1, 32'hFFFF_FFF8);
    do_consume(3'd0);
    expect_st("consume_len0", 32'hFFFF_FFF5, 5'd3, 48'h6677_8800_0000, 1, 32'hFFFF_FFF8);

    do_flush_ack(32'h0000_1002, 32'hFFFF_FFF8, 32'h1234_5678);
    expect_st("flush_with_ack", 32'h0000_1002, 5'd0, 48'h0, 0, 32'h0);
    ack_word(32'h0000_1000, 32'hDDCC_BBAA);
    expect_st("skip2", 32'h0000_1002, 5'd2, 48'hCCDD_0000_0000, 1, 32'h0000_1004);
    ack_word(32'h0000_1004, 32'h4433_2211);
    expect_st("skip2_window", 32'h0000_1002, 5'd6, 48'hCCDD_1122_3344, 1, 32'h0000_1008);

    do_flush(32'h0000_2000);
    expect_st("drain_hold", 32'h0000_2000, 5'd0, 48'h0, 1, 32'h0000_1008);
    do_consume(3'd1);
    expect_st("consume_invalid", 32'h0000_2000, 5'd0, 48'h0, 1, 32'h0000_1008);
    ack_word(32'h0000_1008, 32'hFFFF_FFFF);
    expect_st("drain_discard", 32'h0000_2000, 5'd0, 48'h0, 1, 32'h0000_2000);

    ack_word(32'h0000_2000, 32'h0302_0100);
    ack_word(32'h0000_2004, 32'h0706_0504);
    ack_word(32'h0000_2008, 32'h0B0A_0908);
    expect_st("free_eq_4", 32'h0000_2000, 5'd12, 48'h0001_0203_0405, 1, 32'h0000_200C);
    ack_word(32'h0000_200C, 32'h0F0E_0D0C);
    expect_st("full", 32'h0000_2000, 5'd16, 48'h0001_0203_0405, 0, 32'h0);
    tick(2);
    expect_st("full_idle", 32'h0000_2000, 5'd16, 48'h0001_0203_0405, 0, 32'h0);
    do_consume(3'd4);
    expect_st("pop_not_counted", 32'h0000_2004, 5'd12, 48'h0405_0607_0809, 0, 32'h0);
    ack_word(32'h0000_2010, 32'h1312_1110);
    expect_st("refill", 32'h0000_2004, 5'd16, 48'h0405_0607_0809, 0, 32'h0);

    do_flush(32'hFFFF_FFFE);
    expect_st("flush_idle", 32'hFFFF_FFFE, 5'd0, 48'h0, 0, 32'h0);
    ack_word(32'hFFFF_FFFC, 32'hBBAA_9988);
    expect_st("wrap_addr", 32'hFFFF_FFFE, 5'd2, 48'hAABB_0000_0000, 1, 32'h0000_0000);
    ack_word(32'h0000_0000, 32'h4433_2211);
    expect_st("wrap_window", 32'hFFFF_FFFE, 5'd6, 48'hAABB_1122_3344, 1, 32'h0000_0004);
    do_consume(3'd7);
    expect_st("consume_len7", 32'hFFFF_FFFE, 5'd6, 48'hAABB_1122_3344, 1, 32'h0000_0004);
    do_consume(3'd6);
    expect_st("pc_wrap", 32'h0000_0004, 5'd0, 48'h0, 1, 32'h0000_0004);
    ack_word(32'h0000_0004, 32'h8877_6655);
    expect_st("short_fill", 32'h0000_0004, 5'd4, 48'h5566_7788_0000, 1, 32'h0000_0008);
    do_consume(3'd2);
`ifdef V60_PREFETCH_PARTIAL_EN
    expect_st("short_consume", 32'h0000_0006, 5'd2, 48'h7788_0000_0000, 1, 32'h0000_0008);
`else
    expect_st("short_consume", 32'h0000_0004, 5'd4, 48'h5566_7788_0000, 1, 32'h0000_0008);
`endif

    tick(2);
    chk("addr_queue_drained", 64'(addr_q.size()), 64'd0);
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
